// File: rtl/accum_bus_collector.sv
// accum_bus_collector
// Collects the per-column accumulator result streams of one systolic-array
// row onto a single ordered output stream. A round-robin arbiter accepts at
// most one column per cycle into a first-word-fall-through FIFO whose entries
// carry their column tag. A per-tile counter pulses tile_done once the armed
// number of results has left the FIFO.
// Optional feature: define ACC_BIAS_EN to add the bias_in port; each accepted
// result is then stored as the saturated sum of the column result and bias.
module accum_bus_collector #(
  parameter int NUM_COLS   = 4,
  parameter int ACCUM_BIT  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COLS*ACCUM_BIT-1:0] acc_in,
  input  logic [NUM_COLS-1:0]           acc_in_valid,
  output logic [NUM_COLS-1:0]           acc_in_ready,
  output logic [ACCUM_BIT-1:0]          out_data,
  output logic [COL_W-1:0]              out_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic [CNT_W-1:0]              expected_cnt,
  input  logic                          cnt_load,
  output logic                          tile_done,
  output logic [LVL_W-1:0]              fifo_level
`ifdef ACC_BIAS_EN
  ,
  input  logic [NUM_COLS*ACCUM_BIT-1:0] bias_in
`endif
);

  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);

  logic [COL_W-1:0]     rr_ptr;
  logic [COL_W-1:0]     grant_col;
  logic                 grant_any;
  logic [NUM_COLS-1:0]  grant_vec;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [ACCUM_BIT-1:0] mem_data [FIFO_DEPTH];
  logic [COL_W-1:0]     mem_col  [FIFO_DEPTH];
  logic [ACCUM_BIT-1:0] sel_acc;
  logic [ACCUM_BIT-1:0] push_data;
  logic [CNT_W-1:0]     expected;
  logic [CNT_W-1:0]     drained;
  logic [CNT_W-1:0]     drained_inc;

  // Full is judged on the registered level, so a pop this cycle never frees a slot early
  assign fifo_full = (level == DEPTH_LVL);

  // Round-robin search starting at rr_ptr; first valid column wins when there is room
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_col = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_COLS;
      if (!grant_any && rst_n && !fifo_full && acc_in_valid[idx]) begin
        grant_any = 1'b1;
        grant_col = COL_W'(idx);
      end
    end
  end

  // Expand the winning column into the one-hot ready vector
  always_comb begin
    grant_vec = '0;
    if (grant_any) begin
      grant_vec[grant_col] = 1'b1;
    end
  end

  assign acc_in_ready = grant_vec;
  assign push         = grant_any;
  assign pop          = out_valid && out_ready;
  assign sel_acc      = acc_in[int'(grant_col)*ACCUM_BIT +: ACCUM_BIT];

`ifdef ACC_BIAS_EN
  logic [ACCUM_BIT-1:0] sel_bias;
  logic [ACCUM_BIT:0]   bias_sum;

  assign sel_bias = bias_in[int'(grant_col)*ACCUM_BIT +: ACCUM_BIT];
  assign bias_sum = {sel_acc[ACCUM_BIT-1], sel_acc} + {sel_bias[ACCUM_BIT-1], sel_bias};

  // Clamp the widened sum back into range when the two top bits disagree
  always_comb begin
    push_data = bias_sum[ACCUM_BIT-1:0];
    if (bias_sum[ACCUM_BIT] != bias_sum[ACCUM_BIT-1]) begin
      push_data = bias_sum[ACCUM_BIT] ? {1'b1, {(ACCUM_BIT-1){1'b0}}}
                                      : {1'b0, {(ACCUM_BIT-1){1'b1}}};
    end
  end
`else
  assign push_data = sel_acc;
`endif

  // Advance the round-robin pointer past the granted column, wrapping at the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_col == LAST_COL) ? '0 : grant_col + 1'b1;
    end
  end

  // FIFO storage needs no reset; the outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_col[wr_ptr]  <= grant_col;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (!push && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_col    = out_valid ? mem_col[rd_ptr]  : '0;

  assign drained_inc = drained + 1'b1;

  // Tile bookkeeping: a load rearms and swallows any pop that cycle, otherwise pops are counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected  <= '0;
      drained   <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (cnt_load) begin
        expected <= expected_cnt;
        drained  <= '0;
      end else if (pop) begin
        if ((expected != '0) && (drained_inc == expected)) begin
          drained   <= '0;
          tile_done <= 1'b1;
        end else begin
          drained <= drained_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_bus_collector.sv
// tb_accum_bus_collector
// Directed bench for accum_bus_collector. Each test pushes its hand-derived
// output sequence into a scoreboard queue; an independent monitor pops and
// compares on every accepted output beat. Grant order, FIFO occupancy and
// tile_done pulses are compared against hand-derived values as well.
// Works in both builds; define ACC_BIAS_EN to exercise the bias path.
module tb_accum_bus_collector;

  localparam int NC = 4;
  localparam int AB = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC*AB-1:0] acc_in;
  logic [NC-1:0]   acc_in_valid;
  logic [NC-1:0]   acc_in_ready;
  logic [AB-1:0]   out_data;
  logic [1:0]      out_col;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     expected_cnt;
  logic            cnt_load;
  logic            tile_done;
  logic [3:0]      fifo_level;
`ifdef ACC_BIAS_EN
  logic [NC*AB-1:0] bias_in;
`endif

  logic [AB-1:0]   col_data [NC];
  logic [NC-1:0]   drop_on_accept;
  logic [33:0]     sb_queue [$];
  logic [33:0]     sb_exp;
  logic            last_pop;
  logic            tile_watch;
  logic            tile_pending;
  int              tile_period;
  int              pop_cnt;
  int              tile_hits;
  int              checks = 0;
  int              failures = 0;

  always #5 clk = ~clk;

  // Pack the per-column stimulus words onto the flat input bus
  always_comb begin
    acc_in = '0;
    for (int i = 0; i < NC; i++) begin
      acc_in[i*AB +: AB] = col_data[i];
    end
  end

  accum_bus_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_in       (acc_in),
    .acc_in_valid (acc_in_valid),
    .acc_in_ready (acc_in_ready),
    .out_data     (out_data),
    .out_col      (out_col),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .expected_cnt (expected_cnt),
    .cnt_load     (cnt_load),
    .tile_done    (tile_done),
    .fifo_level   (fifo_level)
`ifdef ACC_BIAS_EN
    ,
    .bias_in      (bias_in)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: optionally compare the ready vector mid-cycle, then update the
  // accepted columns just after the edge (drop valid or advance the data word)
  task automatic applyStimulus(input logic [NC-1:0] exp_ready, input logic chk, input string name);
    logic [NC-1:0] seen;
    @(negedge clk);
    if (chk) checkOutput(name, 64'(acc_in_ready), 64'(exp_ready));
    seen = acc_in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (seen[i]) begin
        if (drop_on_accept[i]) acc_in_valid[i] = 1'b0;
        else col_data[i] = col_data[i] + 1;
      end
    end
  endtask

  task automatic sbPush(input logic [1:0] col, input logic [AB-1:0] data);
    sb_queue.push_back({col, data});
  endtask

  task automatic watchTile(input int period);
    pop_cnt      = 0;
    tile_hits    = 0;
    tile_pending = 1'b0;
    tile_period  = period;
    tile_watch   = 1'b1;
  endtask

  // Scoreboard monitor: every accepted output beat must match the queue head
  always @(negedge clk) begin
    last_pop = rst_n && out_valid && out_ready;
    if (last_pop) begin
      if (sb_queue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_underflow: got col %0d data 0x%0h, expected no output", out_col, out_data);
      end else begin
        sb_exp = sb_queue.pop_front();
        checkOutput("sb_entry", 64'({out_col, out_data}), 64'(sb_exp));
      end
    end
  end

  // Tile monitor: tile_done must appear exactly one cycle after every period-th pop
  always @(negedge clk) begin
    if (tile_watch) begin
      checkOutput("tile_done", 64'(tile_done), 64'(tile_pending));
      if (tile_done === 1'b1) tile_hits++;
      if (rst_n && out_valid && out_ready) begin
        pop_cnt++;
        tile_pending = (tile_period != 0) && ((pop_cnt % tile_period) == 0);
      end else begin
        tile_pending = 1'b0;
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    acc_in_valid   = '1;
    out_ready      = 1'b0;
    expected_cnt   = '0;
    cnt_load       = 1'b0;
    drop_on_accept = '0;
    tile_watch     = 1'b0;
    tile_pending   = 1'b0;
    tile_period    = 0;
    pop_cnt        = 0;
    tile_hits      = 0;
    for (int i = 0; i < NC; i++) col_data[i] = '0;
`ifdef ACC_BIAS_EN
    bias_in = '0;
`endif

    // Reset values, with every column requesting
    #12;
    checkOutput("rst_ready", 64'(acc_in_ready), 64'h0);
    checkOutput("rst_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_data", 64'(out_data), 64'h0);
    checkOutput("rst_col", 64'(out_col), 64'h0);
    checkOutput("rst_done", 64'(tile_done), 64'h0);
    checkOutput("rst_level", 64'(fifo_level), 64'h0);
    @(posedge clk);
    #1;
    acc_in_valid = '0;
    rst_n = 1'b1;

    // Test 1: all four columns at once, served 0,1,2,3; pointer back at 0 afterwards
    out_ready = 1'b1;
    drop_on_accept = '1;
    for (int i = 0; i < NC; i++) begin
      col_data[i] = 32'(10 + i);
      sbPush(2'(i), 32'(10 + i));
    end
    acc_in_valid = 4'b1111;
    applyStimulus(4'b0001, 1'b1, "t1_grant0");
    applyStimulus(4'b0010, 1'b1, "t1_grant1");
    applyStimulus(4'b0100, 1'b1, "t1_grant2");
    applyStimulus(4'b1000, 1'b1, "t1_grant3");
    col_data[0] = 32'd20;
    col_data[3] = 32'd23;
    sbPush(2'd0, 32'd20);
    sbPush(2'd3, 32'd23);
    acc_in_valid = 4'b1001;
    applyStimulus(4'b0001, 1'b1, "t1_rr_wrap0");
    applyStimulus(4'b1000, 1'b1, "t1_rr_wrap3");
    applyStimulus(4'b0000, 1'b1, "t1_idle");

    // Test 2: columns 0 and 2 streaming continuously alternate
    drop_on_accept = '0;
    col_data[0] = 32'd100;
    col_data[2] = 32'd200;
    for (int n = 0; n < 3; n++) begin
      sbPush(2'd0, 32'(100 + n));
      sbPush(2'd2, 32'(200 + n));
    end
    acc_in_valid = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      applyStimulus((n % 2 == 0) ? 4'b0001 : 4'b0100, 1'b1, "t2_alternate");
    end
    acc_in_valid = '0;
    applyStimulus(4'b0000, 1'b1, "t2_idle");

    // Test 3: fill to depth with the sink stalled, then one pop frees one slot
    out_ready = 1'b0;
    col_data[1] = 32'd300;
    for (int n = 0; n < 9; n++) sbPush(2'd1, 32'(300 + n));
    acc_in_valid = 4'b0010;
    for (int n = 0; n < 8; n++) applyStimulus(4'b0010, 1'b1, "t3_fill");
    applyStimulus(4'b0000, 1'b1, "t3_full_block");
    checkOutput("t3_level_full", 64'(fifo_level), 64'd8);
    checkOutput("t3_head_data", 64'(out_data), 64'd300);
    checkOutput("t3_head_col", 64'(out_col), 64'd1);
    out_ready = 1'b1;
    applyStimulus(4'b0000, 1'b1, "t3_full_pop");
    out_ready = 1'b0;
    applyStimulus(4'b0010, 1'b1, "t3_refill");
    acc_in_valid = '0;
    checkOutput("t3_level_refill", 64'(fifo_level), 64'd8);
    out_ready = 1'b1;
    repeat (10) applyStimulus(4'b0000, 1'b0, "");
    checkOutput("t3_drained", 64'(sb_queue.size()), 64'd0);
    checkOutput("t3_level_empty", 64'(fifo_level), 64'd0);

    // Test 4: tile of 5 results, 14 results drained gives pulses after pops 5 and 10
    expected_cnt = 16'd5;
    cnt_load = 1'b1;
    applyStimulus(4'b0000, 1'b1, "t4_load");
    cnt_load = 1'b0;
    watchTile(5);
    col_data[3] = 32'd400;
    for (int n = 0; n < 14; n++) sbPush(2'd3, 32'(400 + n));
    acc_in_valid = 4'b1000;
    repeat (14) applyStimulus(4'b1000, 1'b1, "t4_stream");
    acc_in_valid = '0;
    repeat (4) applyStimulus(4'b0000, 1'b0, "");
    tile_watch = 1'b0;
    checkOutput("t4_pulses", 64'(tile_hits), 64'd2);
    checkOutput("t4_drained", 64'(sb_queue.size()), 64'd0);

    // Test 5: load coincident with a pop ignores that pop; expected 0 never signals
    col_data[0] = 32'd500;
    for (int n = 0; n < 33; n++) sbPush(2'd0, 32'(500 + n));
    acc_in_valid = 4'b0001;
    repeat (3) applyStimulus(4'b0001, 1'b1, "t5_pre");
    expected_cnt = 16'd3;
    cnt_load = 1'b1;
    applyStimulus(4'b0001, 1'b1, "t5_load");
    cnt_load = 1'b0;
    checkOutput("t5_pop_at_load", 64'(last_pop), 64'd1);
    watchTile(3);
    repeat (6) applyStimulus(4'b0001, 1'b1, "t5_stream3");
    expected_cnt = 16'd0;
    cnt_load = 1'b1;
    applyStimulus(4'b0001, 1'b1, "t5_load0");
    cnt_load = 1'b0;
    checkOutput("t5_pulses3", 64'(tile_hits), 64'd2);
    watchTile(0);
    repeat (22) applyStimulus(4'b0001, 1'b1, "t5_stream0");
    acc_in_valid = '0;
    repeat (4) applyStimulus(4'b0000, 1'b0, "");
    tile_watch = 1'b0;
    checkOutput("t5_no_done", 64'(tile_hits), 64'd0);
    checkOutput("t5_enough_pops", 64'(pop_cnt >= 20), 64'd1);
    checkOutput("t5_drained", 64'(sb_queue.size()), 64'd0);

    // Test 6a: biased results saturate at both ends (stored unmodified without the bias path)
    drop_on_accept = '1;
    col_data[0] = 32'h7FFF_FFF0;
    col_data[1] = 32'hFFFF_FFFB;
    col_data[2] = 32'h8000_0005;
`ifdef ACC_BIAS_EN
    bias_in[0*AB +: AB] = 32'h0000_0020;
    bias_in[1*AB +: AB] = 32'h0000_0003;
    bias_in[2*AB +: AB] = 32'hFFFF_FFF0;
    sbPush(2'd1, 32'hFFFF_FFFE);
    sbPush(2'd2, 32'h8000_0000);
    sbPush(2'd0, 32'h7FFF_FFFF);
`else
    sbPush(2'd1, 32'hFFFF_FFFB);
    sbPush(2'd2, 32'h8000_0005);
    sbPush(2'd0, 32'h7FFF_FFF0);
`endif
    acc_in_valid = 4'b0111;
    applyStimulus(4'b0010, 1'b1, "t6_grant1");
    applyStimulus(4'b0100, 1'b1, "t6_grant2");
    applyStimulus(4'b0001, 1'b1, "t6_grant0");
    repeat (2) applyStimulus(4'b0000, 1'b0, "");
`ifdef ACC_BIAS_EN
    bias_in = '0;
`endif
    checkOutput("t6_drained", 64'(sb_queue.size()), 64'd0);

    // Test 6b: reset in the middle of a tile empties everything immediately
    out_ready = 1'b0;
    expected_cnt = 16'd4;
    cnt_load = 1'b1;
    applyStimulus(4'b0000, 1'b1, "t6_load");
    cnt_load = 1'b0;
    drop_on_accept = '0;
    col_data[3] = 32'h600;
    acc_in_valid = 4'b1000;
    repeat (3) applyStimulus(4'b1000, 1'b1, "t6_fill");
    acc_in_valid = '0;
    checkOutput("t6_level_pre_rst", 64'(fifo_level), 64'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_level", 64'(fifo_level), 64'd0);
    checkOutput("t6_rst_data", 64'(out_data), 64'd0);
    checkOutput("t6_rst_done", 64'(tile_done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(4'b0000, 1'b1, "t6_post_idle");
    checkOutput("t6_post_valid", 64'(out_valid), 64'd0);
    drop_on_accept = '1;
    col_data[2] = 32'h55;
    sbPush(2'd2, 32'h55);
    acc_in_valid = 4'b0100;
    applyStimulus(4'b0100, 1'b1, "t6_post_grant");
    repeat (2) applyStimulus(4'b0000, 1'b0, "");
    checkOutput("t6_post_drained", 64'(sb_queue.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
